// File: rtl/ram_dp_param.sv
// Simple dual-port synchronous RAM with one write port, one read port and one clock.
// Features: byte-lane write enables, a selectable same-address collision policy,
// an optional output register stage, and a sequential clear after reset.
// While the clear engine runs, all read and write requests are ignored.
module ram_dp_param #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     din,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     dout,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

    // Reject parameter sets that cannot be built.
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("ram_dp_param: DATA_W must be a multiple of 8");
    end
    if ((DEPTH < 2) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
        $error("ram_dp_param: DEPTH must lie in 2..2**ADDR_W");
    end

    // Replace each enabled byte lane of the old word with the matching lane of the new word.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic              init_busy_q, init_busy_d;
    logic [DATA_W-1:0] stage_q, stage_d;
    logic              stage_vld_q, stage_vld_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;

    logic              wr_acc_s, rd_acc_s;
    logic              wr_in_rng_s, rd_in_rng_s, collide_s;
    logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
    logic [DATA_W-1:0] wr_old_s, wr_word_s, rd_old_s, rd_data_s;
    logic              src_vld_s;
    logic [DATA_W-1:0] src_data_s;

    // Request qualification, write-word merge and read-data selection with collision policy.
    always_comb begin
        wr_acc_s    = wr_en & ~init_busy_q;
        rd_acc_s    = rd_en & ~init_busy_q;
        wr_in_rng_s = ({1'b0, wr_addr} < DEPTH_L);
        rd_in_rng_s = ({1'b0, rd_addr} < DEPTH_L);
        wr_idx_s    = wr_in_rng_s ? wr_addr[IDX_W-1:0] : {IDX_W{1'b0}};
        rd_idx_s    = rd_in_rng_s ? rd_addr[IDX_W-1:0] : {IDX_W{1'b0}};
        wr_old_s    = mem_q[wr_idx_s];
        rd_old_s    = mem_q[rd_idx_s];
        wr_word_s   = merge_lanes(wr_old_s, din, wr_be);
        collide_s   = wr_acc_s & rd_acc_s & wr_in_rng_s & (wr_addr == rd_addr);
        if (!rd_in_rng_s) begin
            rd_data_s = {DATA_W{1'b0}};
        end else if (collide_s && (RD_MODE != 0)) begin
            rd_data_s = wr_word_s;
        end else begin
            rd_data_s = rd_old_s;
        end
    end

    // Clear engine next state: walk the pointer 0..DEPTH-1, then release init_busy.
    always_comb begin
        clr_ptr_d   = clr_ptr_q;
        init_busy_d = init_busy_q;
        if (init_busy_q) begin
            if (clr_ptr_q == LAST_PTR) begin
                clr_ptr_d   = {IDX_W{1'b0}};
                init_busy_d = 1'b0;
            end else begin
                clr_ptr_d   = clr_ptr_q + IDX_W'(1);
                init_busy_d = 1'b1;
            end
        end else begin
            clr_ptr_d   = {IDX_W{1'b0}};
            init_busy_d = 1'b0;
        end
    end

    // Clear engine state register; reset restarts the clear from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_ptr_q   <= {IDX_W{1'b0}};
            init_busy_q <= 1'b1;
        end else begin
            clr_ptr_q   <= clr_ptr_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Storage array: cleared word-by-word after reset, otherwise byte-masked writes (out-of-range dropped).
    always_ff @(posedge clk) begin
        if (init_busy_q && !rst) begin
            mem_q[clr_ptr_q] <= {DATA_W{1'b0}};
        end else if (wr_acc_s && wr_in_rng_s) begin
            mem_q[wr_idx_s] <= wr_word_s;
        end
    end

    // Read pipeline next state: optional internal stage, then dout holds unless new data arrives.
    always_comb begin
        stage_vld_d = rd_acc_s;
        if (rd_acc_s) begin
            stage_d = rd_data_s;
        end else begin
            stage_d = stage_q;
        end
        if (OUT_REG != 0) begin
            src_vld_s  = stage_vld_q;
            src_data_s = stage_q;
        end else begin
            src_vld_s  = rd_acc_s;
            src_data_s = rd_data_s;
        end
        rd_valid_d = src_vld_s;
        if (src_vld_s) begin
            dout_d = src_data_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // Read pipeline and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q     <= {DATA_W{1'b0}};
            stage_vld_q <= 1'b0;
            dout_q      <= {DATA_W{1'b0}};
            rd_valid_q  <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            dout_q      <= dout_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign dout      = dout_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = init_busy_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench for ram_dp_param. Two instances share the stimulus:
// k=0 is DEPTH=16, read-first, 1-cycle latency; k=1 is DEPTH=12, write-first, 2-cycle latency.
module tb_ram_dp_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] din;
    logic [31:0] dout0, dout1;
    logic        rv0, rv1, busy0, busy1;

    always #5 clk = ~clk;

    ram_dp_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .RD_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout0), .rd_valid(rv0), .init_busy(busy0));

    ram_dp_param #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout1), .rd_valid(rv1), .init_busy(busy1));

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] mdl [2][16];
    int          busy_cnt [2] = '{16, 12};
    int          edge_n = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic int dep_of(int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic int mode_of(int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] merge_word(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic push_exp(int k, logic [31:0] d, int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Reference behaviour for one rising edge of instance k.
    task automatic model_edge(int k);
        int          d;
        logic [31:0] rdv;
        d = dep_of(k);
        if (rst) begin
            busy_cnt[k] = d;
            if (k == 0) sb0.delete();
            else        sb1.delete();
        end else if (busy_cnt[k] > 0) begin
            mdl[k][d - busy_cnt[k]] = 32'h0;
            busy_cnt[k]--;
        end else begin
            if (rd_en) begin
                if (int'(rd_addr) < d) begin
                    rdv = mdl[k][rd_addr];
                    if (mode_of(k) == 1 && wr_en && wr_addr == rd_addr)
                        rdv = merge_word(rdv, din, wr_be);
                end else begin
                    rdv = 32'h0;
                end
                push_exp(k, rdv, edge_n + lat_of(k) - 1);
            end
            if (wr_en && int'(wr_addr) < d)
                mdl[k][wr_addr] = merge_word(mdl[k][wr_addr], din, wr_be);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic drive(bit we, logic [3:0] wa, logic [3:0] be, logic [31:0] d, bit re, logic [3:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        din     = d;
        rd_en   = re;
        rd_addr = ra;
        step();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    // Monitor: compares one instance's outputs against the model and its scoreboard queue.
    task automatic check_port(int k, logic rv, logic [31:0] dq, logic bz);
        exp_t e;
        bit   have;
        bit   eb;
        if (rst) begin
            n_chk++;
            if (bz !== 1'b1 || rv !== 1'b0 || dq !== 32'h0) begin
                n_fail++;
                $display("FAIL k%0d reset_state: busy=%b valid=%b dout=%h expected busy=1 valid=0 dout=0", k, bz, rv, dq);
            end
        end else begin
            eb = (busy_cnt[k] > 0);
            n_chk++;
            if (bz !== eb) begin
                n_fail++;
                $display("FAIL k%0d init_busy edge %0d: got %b expected %b", k, edge_n, bz, eb);
            end
            if (eb) begin
                n_chk++;
                if (rv !== 1'b0 || dq !== 32'h0) begin
                    n_fail++;
                    $display("FAIL k%0d busy_outputs edge %0d: valid=%b dout=%h expected 0/0", k, edge_n, rv, dq);
                end
            end
            if (rv === 1'b1) begin
                have = 1'b0;
                if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
                if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
                n_chk++;
                if (!have) begin
                    n_fail++;
                    $display("FAIL k%0d spurious_valid edge %0d: dout=%h with no read outstanding", k, edge_n, dq);
                end else if (dq !== e.data || e.due != edge_n) begin
                    n_fail++;
                    $display("FAIL k%0d read_data edge %0d: got %h expected %h (due edge %0d)", k, edge_n, dq, e.data, e.due);
                end
            end else begin
                have = 1'b0;
                if (k == 0 && sb0.size() > 0 && sb0[0].due <= edge_n) begin e = sb0.pop_front(); have = 1'b1; end
                if (k == 1 && sb1.size() > 0 && sb1[0].due <= edge_n) begin e = sb1.pop_front(); have = 1'b1; end
                if (have) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL k%0d missing_valid edge %0d: valid=0 expected data %h", k, edge_n, e.data);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        #1;
        check_port(0, rv0, dout0, busy0);
        check_port(1, rv1, dout1, busy1);
    end

    initial begin
        logic [3:0] wa, ra;
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; wr_addr = 4'h0; rd_addr = 4'h0; wr_be = 4'h0; din = 32'h0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        // Requests during clear must be ignored.
        for (int i = 0; i < 12; i++) drive(1'b1, 4'(i), 4'hF, 32'hFFFF_FFFF, 1'b1, 4'(i));
        idle(4);
        for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
        idle(2);
        // Fill and back-to-back readback.
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 4'hF, 32'hA0 + 32'(i), 1'b0, 4'h0);
        for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
        idle(2);
        // Byte-lane enables.
        drive(1'b1, 4'h3, 4'hF, 32'h1122_3344, 1'b0, 4'h0);
        drive(1'b1, 4'h3, 4'h5, 32'hAABB_CCDD, 1'b0, 4'h0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3);
        idle(2);
        // Same-address collision, then a plain re-read.
        drive(1'b1, 4'h5, 4'hF, 32'h10, 1'b0, 4'h0);
        drive(1'b1, 4'h5, 4'hF, 32'h99, 1'b1, 4'h5);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h5);
        idle(2);
        // Latency and out-of-range access.
        drive(1'b1, 4'h2, 4'hF, 32'h5A, 1'b0, 4'h0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h2);
        idle(3);
        drive(1'b1, 4'hD, 4'hF, 32'h77, 1'b0, 4'h0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hD);
        idle(3);
        // Random traffic with biased collisions.
        for (int i = 0; i < 400; i++) begin
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), 32'($urandom()),
                  1'($urandom_range(0, 1)), ra);
        end
        idle(3);
        // Reset, then reset again mid-clear.
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(7);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle(16);
        for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
        idle(4);
        n_chk++;
        if (sb0.size() != 0) begin
            n_fail++;
            $display("FAIL k0 drain: %0d reads outstanding, expected 0", sb0.size());
        end
        n_chk++;
        if (sb1.size() != 0) begin
            n_fail++;
            $display("FAIL k1 drain: %0d reads outstanding, expected 0", sb1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
Parametrised simple dual-port synchronous RAM: one write port, one read port, single clock. Successor to the fixed 16x8 dual-port RAM. Adds:
- byte-lane write enables
- a selectable read-during-write collision mode
- an optional output pipeline register with a read-valid strobe
- a sequential self-clear engine after reset

Used as a generic buffer and storage macro by FIFO and packet blocks.

Parameters:
DATA_W, 8, data word width in bits; must be a multiple of 8.
DEPTH, 16, number of words; 2 <= DEPTH <= 2**ADDR_W, need not be a power of 2.
ADDR_W, 4, address width in bits.
RD_MODE, 0, same-address collision policy: 0 = read-first (old data), 1 = write-first (new data bypassed).
OUT_REG, 0, 0 = 1-cycle read latency, 1 = 2-cycle read latency (extra output register).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_be  input  DATA_W/8  byte-lane enables; bit b covers din[8b+7:8b]
din  input  DATA_W  write data
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
dout  output  DATA_W  read data, registered
rd_valid  output  1  one-cycle pulse marking new data on dout
init_busy  output  1  high while the clear engine runs; requests are ignored

Behaviour:
- Reset (asynchronous, rst=1):
  - dout=0, rd_valid=0, init_busy=1, clear pointer=0, internal pipeline stage and valid cleared.
  - Memory contents are not cleared asynchronously.
- Clear engine:
  - First rising edge with rst=0 starts it.
  - One word is zeroed per edge, pointer 0..DEPTH-1; DEPTH edges in total.
  - init_busy drops after the edge that writes word DEPTH-1.
  - rst reasserted mid-clear restarts at pointer 0 after deassertion.
- While init_busy=1: wr_en and rd_en are ignored; rd_valid stays 0; dout stays 0.
- Write, at an edge with wr_en=1 and init_busy=0:
  - Each lane b with wr_be[b]=1 takes din lane b; other lanes keep their old value.
  - wr_be all zero means no change.
- Read, at edge N with rd_en=1 and init_busy=0:
  - OUT_REG=0: dout is updated at edge N; rd_valid=1 for the cycle following edge N.
  - OUT_REG=1: data passes through an internal stage at N; dout and rd_valid update at N+1.
  - Back-to-back reads give one result per cycle.
- rd_en=0: dout holds its last value; rd_valid=0 in the corresponding cycle.
- Collision (rd_en and wr_en both accepted, rd_addr==wr_addr):
  - RD_MODE=0: pre-write word is returned.
  - RD_MODE=1: merged word is returned: enabled lanes from din, disabled lanes old.
  - Memory is written in both modes.
- Out-of-range address (addr >= DEPTH):
  - Write is discarded.
  - Read returns all zeros with rd_valid asserted normally.
- Simultaneous read and write to different addresses are independent; there are no stalls.
- Elaboration must fail if DATA_W%8 != 0 or DEPTH > 2**ADDR_W.

Test Plan:
- Reset/clear: DEPTH=16. Pulse rst, then release. Required: init_busy=1 for exactly 16 edges. A read of every address afterwards returns 0x00. A wr_en issued during clear leaves memory at 0.
- Fill/readback: DATA_W=8, OUT_REG=0. Write mem[i]=0xA0+i for i=0..15, then read 0..15 back-to-back. Required: dout=0xA0+i one edge after each request; rd_valid high for 16 consecutive cycles.
- Byte enables: DATA_W=32. Write 0x11223344 to addr 3 with be=1111, then 0xAABBCCDD with be=0101, then read addr 3. Required: 0x11BB33DD.
- Collision: DATA_W=8, mem[5]=0x10. Same-edge write 0x99 and read, both to addr 5. Required: RD_MODE=0 returns 0x10; RD_MODE=1 returns 0x99. A subsequent read returns 0x99 in both modes.
- Latency/out-of-range: OUT_REG=1, DEPTH=12. Read addr 2 (holding 0x5A). Required: dout=0x5A and rd_valid asserted 2 edges after the request. Write 0x77 to addr 13, then read addr 13. Required: 0x00 with rd_valid=1.
- Reset mid-clear: assert rst after 7 clear edges, then release. Required: 16 full clear edges follow, and all words read back 0.
